decryption: RTL and testbench
=============================

DECRYPTION -- requirements
Module: decryption

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, AES-128 round count; only 10 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to decrypt cipher_text; level sampled each rising clk.
REQ-005 cipher_text  input  128  ciphertext block; byte 0 in bits [127:120], column-major AES state order.
REQ-006 key_in  input  128  current round key from key_expansion, served rk10 first down to rk0.
REQ-007 ready_dec  output  1  high in a cycle whose rising edge consumes key_in; key_expansion then presents the next lower round key.
REQ-008 plain_text  output  128  registered plaintext result.
REQ-009 done_dec  output  1  one-cycle completion pulse.

Function
REQ-010 The block SHALL implement FIPS-197 AES-128 inverse cipher, one round per clock, with round keys supplied externally.
REQ-011 FSM states SHALL be IDLE, ROUND and DONE.
REQ-012 In IDLE with start high, the rising edge SHALL load state <= cipher_text XOR key_in (rk10), set round counter to 9 and enter ROUND.
REQ-013 Each ROUND edge SHALL apply InvShiftRows, then InvSubBytes, then XOR key_in, then InvMixColumns (omitted when counter = 0), and decrement the counter.
REQ-014 On the edge with counter = 0 the block SHALL write the result to plain_text and enter DONE.
REQ-015 DONE SHALL last exactly one cycle with done_dec = 1, then return to IDLE.
REQ-016 Latency: start sampled at edge N; plain_text valid and done_dec high from edge N+10 to N+11.
REQ-017 ready_dec SHALL be combinational: high when (IDLE and start) or ROUND; low in DONE and in IDLE without start. The block thereby consumes 11 keys per block.
REQ-018 plain_text SHALL hold its value until the next completion, so it stays stable after done_dec falls.
REQ-019 start while in ROUND or DONE SHALL be ignored without effect; start held high in IDLE after DONE SHALL begin a new block.
REQ-020 cipher_text SHALL be sampled only at the start edge; later changes SHALL NOT affect the result.
REQ-021 S-box lookup SHALL be combinational, with 16 parallel inverse S-box instances.

Reset
REQ-022 On reset_n low, the FSM SHALL go to IDLE immediately; state, counter and plain_text SHALL clear to 0; done_dec SHALL be 0.
REQ-023 Reset mid-operation SHALL abort the block with no done_dec pulse; the first start after release SHALL run normally.

Structure
REQ-024 Shared package aes_pkg SHALL hold the 256-entry inverse S-box constant, the GF(2^8) xtime/multiply functions, the state FSM typedef and NUM_ROUNDS.
REQ-025 One sub-module, inv_mix_column (32-bit column in, 32-bit out), SHALL be instantiated four times; InvShiftRows and InvSubBytes SHALL be inline.

Verification
REQ-026 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c via key_expansion, cipher 3925841d02dc09fbdc118597196a0b32 -> plain_text 3243f6a8885a308d313198a2e0370734 at done_dec.
REQ-027 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
REQ-028 Round trip: encryption of 3243f6a8885a308d313198a2e0370734 followed by decryption of its output -> original plaintext; done_dec exactly 10 edges after the start edge, and one cycle wide.
REQ-029 Assert reset_n low at round 5, then restart with the B vector -> no done_dec during the aborted run; second run gives the correct result.
REQ-030 Pulse start again during ROUND -> ignored; result and latency unchanged; ready_dec high exactly 11 cycles per block.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: inverse S-box, GF(2^8) arithmetic, FSM state type, round count.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Entry i of the inverse S-box sits at index i (first byte of the literal is entry 0).
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// InvMixColumns on one 32-bit column; row 0 byte in bits [31:24].
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] column,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = column;

    assign mixed = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
    };

endmodule

// File: rtl/decryption.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys streamed in rk10..rk0.
module decryption #(
    parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] cipher_text,
    input  logic [127:0] key_in,
    output logic         ready_dec,
    output logic [127:0] plain_text,
    output logic         done_dec
);

    import aes_pkg::state_t;
    import aes_pkg::IDLE;
    import aes_pkg::ROUND;
    import aes_pkg::DONE;
    import aes_pkg::INV_SBOX;

    localparam int unsigned CNT_W = 4;

    state_t             fsm_q, fsm_d;
    logic [127:0]       state_q;
    logic [CNT_W-1:0]   round_q;
    logic [127:0]       shifted, subbed, keyed, mixed, round_out;

    // InvShiftRows: row r rotates right by r columns
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8*(r + 4*c) -: 8] = state_q[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
            end
        end
    end

    always_comb begin
        subbed = '0;
        for (int i = 0; i < 16; i++) begin
            subbed[127 - 8*i -: 8] = INV_SBOX[shifted[127 - 8*i -: 8]];
        end
    end

    assign keyed = subbed ^ key_in;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        inv_mix_column u_mix (
            .column (keyed[127 - 32*c -: 32]),
            .mixed  (mixed[127 - 32*c -: 32])
        );
    end

    assign round_out = (round_q == '0) ? keyed : mixed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fsm_q <= IDLE;
        else          fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start) fsm_d = ROUND;
            ROUND:   if (round_q == '0) fsm_d = DONE;
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Key handshake: a key is consumed on every edge that loads or advances the state
    always_comb begin
        ready_dec = 1'b0;
        if ((fsm_q == IDLE && start) || fsm_q == ROUND) ready_dec = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= '0;
            round_q    <= '0;
            plain_text <= '0;
            done_dec   <= 1'b0;
        end else begin
            done_dec <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q <= cipher_text ^ key_in;
                        round_q <= CNT_W'(NUM_ROUNDS - 1);
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    if (round_q == '0) begin
                        plain_text <= round_out;
                        done_dec   <= 1'b1;
                    end else begin
                        round_q <= round_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decryption.sv
// Bench for decryption: acts as key_expansion and checks against an AES-128 encryption model.
module tb_decryption;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [127:0] cipher_text;
    logic [127:0] key_in;
    logic         ready_dec;
    logic [127:0] plain_text;
    logic         done_dec;

    int checks;
    int errors;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk [0:10];
    logic [3:0]   kidx;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    decryption #(.NUM_ROUNDS(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .cipher_text (cipher_text),
        .key_in      (key_in),
        .ready_dec   (ready_dec),
        .plain_text  (plain_text),
        .done_dec    (done_dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key server: presents rk10 first, steps down on each consumed key, wraps after rk0
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       kidx <= 4'd10;
        else if (ready_dec) kidx <= (kidx == 4'd0) ? 4'd10 : kidx - 4'd1;
    end
    assign key_in = rk[kidx];

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward S-box from its definition: multiplicative inverse then affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[w + 4*c] = t[w + 4*((c + w) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
                    s[4*c+3] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One block starting at the current negedge; checks latency, pulse width, hold and key count
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                             input logic [127:0] pt, input bit hold, input bit pulse);
        int rdy;
        rdy = 0;
        expand(key);
        cipher_text = ct;
        start = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            #1;
            if (ready_dec) rdy++;
            @(posedge clk);
            @(negedge clk);
            if (!hold) start = (pulse && e == 3);
            cipher_text = {$urandom(), $urandom(), $urandom(), $urandom()};
            chk({tag, "_done"}, 128'(done_dec), 128'(e == 10));
            if (e == 10) chk({tag, "_plain"}, plain_text, pt);
            if (e == 11) chk({tag, "_hold"}, plain_text, pt);
        end
        chk({tag, "_ready_cnt"}, 128'(rdy), 128'(11));
    endtask

    initial begin
        logic [127:0] k, p, c;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        start = 1'b0;
        cipher_text = '0;
        for (int i = 0; i <= 10; i++) rk[i] = '0;
        build_sbox();

        repeat (2) @(negedge clk);
        chk("rst_plain", plain_text, 128'h0);
        chk("rst_done", 128'(done_dec), 128'h0);
        chk("rst_ready", 128'(ready_dec), 128'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 128'(ready_dec), 128'h0);

        run_block("c1", KEY_C, CT_C, PT_C, 1'b0, 1'b0);
        run_block("b_pulse", KEY_B, CT_B, PT_B, 1'b0, 1'b1);
        run_block("b_hold", KEY_B, CT_B, PT_B, 1'b1, 1'b0);
        run_block("c1_b2b", KEY_C, CT_C, PT_C, 1'b0, 1'b0);

        // Abort after five rounds, then restart with the same vector
        expand(KEY_B);
        cipher_text = CT_B;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_nodone", 128'(done_dec), 128'h0);
        end
        reset_n = 1'b0;
        #1;
        chk("abort_plain", plain_text, 128'h0);
        chk("abort_done", 128'(done_dec), 128'h0);
        chk("abort_ready", 128'(ready_dec), 128'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_abort_quiet", 128'(done_dec), 128'h0);
        end
        run_block("b_restart", KEY_B, CT_B, PT_B, 1'b0, 1'b0);

        // Round trip on random keys and plaintexts
        for (int n = 0; n < 6; n++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand(k);
            c = encrypt(p);
            run_block($sformatf("rand%0d", n), k, c, p, 1'b0, (n % 2) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
